// File: rtl/key_chord_pkg.sv
// Shared types and constants for the keyboard chord decoder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package key_chord_pkg;

   localparam int CK_KEY_W = 8;
   localparam int CK_ACT_W = 4;

   // Reserved and default action identifiers
   localparam logic [CK_ACT_W-1:0] ACT_QUIT       = 4'hF;
   localparam logic [CK_ACT_W-1:0] ACT_FULLSCREEN = 4'h1;
   localparam logic [CK_ACT_W-1:0] ACT_LOG_TOGGLE = 4'h2;
   localparam logic [CK_ACT_W-1:0] ACT_STATUS     = 4'h3;

   typedef struct packed {
      logic                en;
      logic                mod_en;
      logic [CK_KEY_W-1:0] mod;
      logic [CK_KEY_W-1:0] key;
      logic [CK_ACT_W-1:0] act;
   } chord_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      PUSH = 2'd2
   } kcd_state_e;

endpackage

// File: rtl/kcd_action_fifo.sv
// Shift-register FIFO carrying {ch, act} action tokens; head is a plain register.
// Latency: a push is visible at the head the cycle after it is written, no bypass.
// Backpressure: full blocks a push unless a pop happens in the same cycle.
module kcd_action_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         head_valid,
   output logic [W-1:0] head_data,
   output logic         full
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [CNT_W-1:0] count;
   logic             do_pop;
   logic             do_push;
   logic [PTR_W-1:0] wpos;

   assign full       = (count == CNT_W'(DEPTH));
   assign do_pop     = pop && (count != '0);
   assign do_push    = push && (!full || do_pop);
   // After a pop the tail slides down one place, so the write slot follows it
   assign wpos       = PTR_W'(count - CNT_W'(do_pop));
   assign head_valid = (count != '0);
   assign head_data  = mem[0];

   // Storage shifts toward slot 0 on pop; new token lands behind the last valid one
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
         end
         if (do_push) mem[wpos] <= push_data;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/key_chord_decoder.sv
// Tracks held keys per channel, matches key-downs against a chord table, emits action tokens.
// Latency: match at entry k -> act_valid 3+k cycles after accept; quit -> 2 cycles.
// Backpressure: ev_ready only in IDLE; full FIFO drops tokens into drop_cnt. Option: KCD_REPEAT_FILTER_EN.
module key_chord_decoder
   import key_chord_pkg::*;
#(
   parameter  int NUM_CH     = 2,
   parameter  int KEY_W      = CK_KEY_W,
   parameter  int NUM_CHORDS = 8,
   parameter  int ACT_W      = CK_ACT_W,
   parameter  int FIFO_DEPTH = 4,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int IDX_W      = $clog2(NUM_CHORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ev_valid,
   output logic              ev_ready,
   input  logic [CH_W-1:0]   ev_ch,
   input  logic [KEY_W-1:0]  ev_key,
   input  logic              ev_down,
   input  logic              ev_quit,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic              cfg_en,
   input  logic              cfg_mod_en,
   input  logic [KEY_W-1:0]  cfg_mod,
   input  logic [KEY_W-1:0]  cfg_key,
   input  logic [ACT_W-1:0]  cfg_act,
   output logic              act_valid,
   input  logic              act_ready,
   output logic [CH_W-1:0]   act_ch,
   output logic [ACT_W-1:0]  act_id,
   output logic [NUM_CH-1:0] held_any,
   output logic [15:0]       drop_cnt
);

   localparam int              NUM_KEYS = 2 ** KEY_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHORDS - 1);
   localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

   kcd_state_e          state_q, state_d;
   logic [NUM_KEYS-1:0] held [NUM_CH];
   chord_entry_t        tbl  [NUM_CHORDS];
   chord_entry_t        cur;
   logic [CH_W-1:0]     lat_ch;
   logic [KEY_W-1:0]    lat_key;
   logic [ACT_W-1:0]    lat_act;
   logic [IDX_W-1:0]    idx_q;

   logic accept, ch_ok, is_repeat, entry_hit, fifo_full, act_pop;
   logic set_held, clr_held, start_scan, start_quit, scan_hit, idx_inc, push_en, drop;

   // Held while reset is asserted so no event slips in during reset
   assign ev_ready = rst_n && (state_q == IDLE);
   assign accept   = ev_valid && ev_ready;
   assign ch_ok    = ({1'b0, ev_ch} < NUM_CH_L);
   assign act_pop  = act_valid && act_ready;

`ifdef KCD_REPEAT_FILTER_EN
   // Autorepeat key-downs arrive with the key already held
   assign is_repeat = held[ev_ch][ev_key];
`else
   assign is_repeat = 1'b0;
`endif

   // The table is registered, so a write this cycle is seen by SCAN only next cycle
   assign cur       = tbl[idx_q];
   assign entry_hit = cur.en && (cur.key == lat_key) && (!cur.mod_en || held[lat_ch][cur.mod]);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and datapath control
   always_comb begin
      state_d    = state_q;
      set_held   = 1'b0;
      clr_held   = 1'b0;
      start_scan = 1'b0;
      start_quit = 1'b0;
      scan_hit   = 1'b0;
      idx_inc    = 1'b0;
      push_en    = 1'b0;
      drop       = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept && ch_ok) begin
               if (ev_quit) begin
                  start_quit = 1'b1;
                  state_d    = PUSH;
               end else if (!ev_down) begin
                  clr_held = 1'b1;
               end else if (!is_repeat) begin
                  set_held   = 1'b1;
                  start_scan = 1'b1;
                  state_d    = SCAN;
               end
            end
         end
         SCAN: begin
            if (entry_hit) begin
               scan_hit = 1'b1;
               state_d  = PUSH;
            end else if (idx_q == LAST_IDX) begin
               state_d = IDLE;
            end else begin
               idx_inc = 1'b1;
            end
         end
         PUSH: begin
            state_d = IDLE;
            if (!fifo_full || act_pop) push_en = 1'b1;
            else                       drop    = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Per-channel held-key bitmap
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) held[c] <= '0;
      end else begin
         if (set_held) held[ev_ch][ev_key] <= 1'b1;
         if (clr_held) held[ev_ch][ev_key] <= 1'b0;
      end
   end

   // Programmable chord table
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CHORDS; i++) tbl[i] <= '0;
      end else if (cfg_we) begin
         tbl[cfg_idx] <= '{en: cfg_en, mod_en: cfg_mod_en, mod: cfg_mod, key: cfg_key, act: cfg_act};
      end
   end

   // Latched event, scan index and drop counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lat_ch   <= '0;
         lat_key  <= '0;
         lat_act  <= '0;
         idx_q    <= '0;
         drop_cnt <= '0;
      end else begin
         if (start_scan) begin
            lat_ch  <= ev_ch;
            lat_key <= ev_key;
            idx_q   <= '0;
         end
         if (start_quit) begin
            lat_ch  <= ev_ch;
            lat_act <= '1;
         end
         if (scan_hit) lat_act <= cur.act;
         if (idx_inc)  idx_q   <= idx_q + 1'b1;
         if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   // Held-any summary per channel
   always_comb begin
      held_any = '0;
      for (int c = 0; c < NUM_CH; c++) held_any[c] = |held[c];
   end

   kcd_action_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (CH_W + ACT_W)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push_en),
      .push_data  ({lat_ch, lat_act}),
      .pop        (act_pop),
      .head_valid (act_valid),
      .head_data  ({act_ch, act_id}),
      .full       (fifo_full)
   );

endmodule

// File: tb/tb_key_chord_decoder.sv
// Bench for key_chord_decoder: transaction-level model checked every cycle plus directed literals.
// Latency: n/a.
// Backpressure: n/a.
module tb_key_chord_decoder;

   localparam int NUM_CH = 2, KEY_W = 8, NUM_CHORDS = 8, ACT_W = 4, FIFO_DEPTH = 4;
`ifdef KCD_REPEAT_FILTER_EN
   localparam int REP_TOKENS = 1;
`else
   localparam int REP_TOKENS = 2;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ev_valid = 1'b0, ev_ready, ev_down = 1'b0, ev_quit = 1'b0;
   logic [0:0] ev_ch = '0;
   logic [7:0] ev_key = '0;
   logic       cfg_we = 1'b0, cfg_en = 1'b0, cfg_mod_en = 1'b0;
   logic [2:0] cfg_idx = '0;
   logic [7:0] cfg_mod = '0, cfg_key = '0;
   logic [3:0] cfg_act = '0;
   logic       act_valid, act_ready = 1'b0;
   logic [0:0] act_ch;
   logic [3:0] act_id;
   logic [1:0] held_any;
   logic [15:0] drop_cnt;

   always #5 clk = ~clk;

   key_chord_decoder #(
      .NUM_CH(NUM_CH), .KEY_W(KEY_W), .NUM_CHORDS(NUM_CHORDS), .ACT_W(ACT_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ch(ev_ch), .ev_key(ev_key),
      .ev_down(ev_down), .ev_quit(ev_quit),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_mod_en(cfg_mod_en),
      .cfg_mod(cfg_mod), .cfg_key(cfg_key), .cfg_act(cfg_act),
      .act_valid(act_valid), .act_ready(act_ready), .act_ch(act_ch), .act_id(act_id),
      .held_any(held_any), .drop_cnt(drop_cnt)
   );

   int vectors = 0, miscompares = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { bit en; bit mod_en; bit [7:0] mod; bit [7:0] key; bit [3:0] act; } ent_t;
   bit [255:0] m_held [NUM_CH];
   ent_t       m_tbl  [NUM_CHORDS];
   bit [4:0]   m_q[$];          // {ch, act}
   int         m_drop = 0, cyc = 0, ready_cyc = 0, pend_cyc = 0;
   bit         pend_vld = 0;
   bit [4:0]   pend_tok;
   bit         chk_en = 0;
   int         pop_cnt = 0;

   function automatic bit m_ready();
      return (rst_n === 1'b1) && (cyc >= ready_cyc);
   endfunction

   always @(posedge clk) begin
      bit was_full, pop, rep;
      int k;
      if (rst_n !== 1'b1) begin
         foreach (m_held[c]) m_held[c] = '0;
         foreach (m_tbl[i]) m_tbl[i] = '{0, 0, 0, 0, 0};
         m_q.delete();
         m_drop = 0; ready_cyc = 0; pend_vld = 0;
      end else begin
         was_full = (m_q.size() == FIFO_DEPTH);
         pop = (m_q.size() > 0) && act_ready;
         if (pop) void'(m_q.pop_front());
         if (pend_vld && pend_cyc == cyc) begin
            pend_vld = 0;
            if (!was_full || pop) m_q.push_back(pend_tok);
            else if (m_drop < 65535) m_drop++;
         end
         if (cfg_we) m_tbl[cfg_idx] = '{cfg_en, cfg_mod_en, cfg_mod, cfg_key, cfg_act};
         if (ev_valid && m_ready()) begin
            if (ev_quit) begin
               pend_vld = 1; pend_cyc = cyc + 1; pend_tok = {ev_ch, 4'hF}; ready_cyc = cyc + 2;
            end else if (!ev_down) begin
               m_held[ev_ch][ev_key] = 1'b0;
            end else begin
               rep = 0;
`ifdef KCD_REPEAT_FILTER_EN
               rep = m_held[ev_ch][ev_key];
`endif
               if (!rep) begin
                  m_held[ev_ch][ev_key] = 1'b1;
                  k = -1;
                  for (int i = 0; i < NUM_CHORDS; i++)
                     if (k < 0 && m_tbl[i].en && m_tbl[i].key == ev_key &&
                         (!m_tbl[i].mod_en || m_held[ev_ch][m_tbl[i].mod])) k = i;
                  if (k >= 0) begin
                     pend_vld = 1; pend_cyc = cyc + 2 + k; pend_tok = {ev_ch, m_tbl[k].act};
                     ready_cyc = cyc + 3 + k;
                  end else begin
                     ready_cyc = cyc + 1 + NUM_CHORDS;
                  end
               end
            end
         end
      end
      cyc++;
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("ev_ready", ev_ready, m_ready());
         check("act_valid", act_valid, m_q.size() > 0);
         if (m_q.size() > 0) begin
            check("act_ch", act_ch, m_q[0][4]);
            check("act_id", act_id, m_q[0][3:0]);
         end
         check("held_any", held_any, {|m_held[1], |m_held[0]});
         check("drop_cnt", drop_cnt, m_drop[15:0]);
         if (rst_n && act_valid && act_ready) pop_cnt++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!m_ready() && n < 100) begin tick(); n++; end
      if (!m_ready()) begin
         vectors++; miscompares++;
         $display("FAIL wait_ready: timeout after %0d cycles", n);
      end
   endtask

   task automatic send(input bit ch, input bit [7:0] key, input bit down, input bit quit);
      wait_ready();
      ev_valid = 1; ev_ch = ch; ev_key = key; ev_down = down; ev_quit = quit;
      tick();
      ev_valid = 0; ev_quit = 0;
   endtask

   task automatic cfg(input int idx, input bit en, input bit mod_en, input bit [7:0] mod,
                      input bit [7:0] key, input bit [3:0] act);
      cfg_we = 1; cfg_idx = idx[2:0]; cfg_en = en; cfg_mod_en = mod_en;
      cfg_mod = mod; cfg_key = key; cfg_act = act;
      tick();
      cfg_we = 0;
   endtask

   task automatic pop_one();
      act_ready = 1; tick(); act_ready = 0;
   endtask

   initial begin
      int p0;
      repeat (3) tick();
      chk_en = 1;
      check("rst_ev_ready_low", ev_ready, 0);
      rst_n = 1; #1;
      check("rst_ev_ready_first", ev_ready, 1);
      check("rst_act_valid", act_valid, 0);
      check("rst_act_ch", act_ch, 0);
      check("rst_act_id", act_id, 0);
      check("rst_held_any", held_any, 0);
      check("rst_drop_cnt", drop_cnt, 0);

      // Quit on ch 1 with an empty table
      send(1, 8'h00, 0, 1);
      check("quit_c1_valid", act_valid, 0);
      tick();
      check("quit_valid", act_valid, 1);
      check("quit_ch", act_ch, 1);
      check("quit_id", act_id, 4'hF);
      check("quit_drop", drop_cnt, 0);
      check("quit_ready", ev_ready, 1);
      pop_one();
      check("quit_popped", act_valid, 0);

      // Plain chord at entry 0
      cfg(0, 1, 0, 8'h00, 8'h29, 4'hF);
      send(0, 8'h29, 1, 0);
      check("plain_c1", act_valid, 0); tick();
      check("plain_c2", act_valid, 0); tick();
      check("plain_valid", act_valid, 1);
      check("plain_id", act_id, 4'hF);
      check("plain_held", held_any, 2'b01);
      pop_one();
      send(0, 8'h29, 0, 0);
      check("plain_release", held_any, 2'b00);

      // Modifier chord at entry 2
      cfg(2, 1, 1, 8'hE2, 8'h28, 4'h1);
      send(0, 8'h28, 1, 0);
      repeat (10) tick();
      check("mod_alone", act_valid, 0);
      send(0, 8'h28, 0, 0);
      send(0, 8'hE2, 1, 0);
      send(0, 8'h28, 1, 0);
      for (int i = 1; i < 5; i++) begin check("mod_early", act_valid, 0); tick(); end
      check("mod_valid", act_valid, 1);
      check("mod_id", act_id, 4'h1);
      pop_one();
      send(0, 8'h28, 0, 0);
      send(0, 8'hE2, 0, 0);
      send(1, 8'hE2, 1, 0);
      send(0, 8'h28, 1, 0);
      repeat (10) tick();
      check("mod_cross_ch", act_valid, 0);
      send(0, 8'h28, 0, 0);
      send(1, 8'hE2, 0, 0);

      // Lowest matching entry wins
      cfg(1, 1, 0, 8'h00, 8'h09, 4'h2);
      cfg(5, 1, 0, 8'h00, 8'h09, 4'h3);
      send(0, 8'h09, 1, 0);
      repeat (3) tick();
      check("prio_valid", act_valid, 1);
      check("prio_id", act_id, 4'h2);
      pop_one();
      repeat (10) tick();
      check("prio_single", act_valid, 0);
      send(0, 8'h09, 0, 0);

      // FIFO overflow with six quits
      for (int i = 0; i < 6; i++) send(i[0], 8'h00, 0, 1);
      tick(); tick();
      check("full_drop", drop_cnt, 2);
      act_ready = 1;
      for (int j = 0; j < 4; j++) begin
         check("full_drain_valid", act_valid, 1);
         check("full_drain_ch", act_ch, j % 2);
         check("full_drain_id", act_id, 4'hF);
         tick();
      end
      check("full_empty", act_valid, 0);

      // Autorepeat key-down
      cfg(3, 1, 0, 8'h00, 8'h44, 4'h3);
      p0 = pop_cnt;
      send(0, 8'h44, 1, 0);
      send(0, 8'h44, 1, 0);
      repeat (15) tick();
      check("repeat_tokens", pop_cnt - p0, REP_TOKENS);
      send(0, 8'h44, 0, 0);

      // Reset in the middle of a scan that would match
      cfg(7, 1, 0, 8'h00, 8'h55, 4'h2);
      p0 = pop_cnt;
      send(0, 8'h55, 1, 0);
      tick(); tick();
      rst_n = 0; tick(); rst_n = 1;
      repeat (12) tick();
      check("rst_scan_tokens", pop_cnt - p0, 0);
      check("rst_scan_held", held_any, 0);
      act_ready = 0;

      // Randomised traffic
      for (int n = 0; n < 3000; n++) begin
         act_ready = ($urandom_range(0, 3) != 0);
         cfg_we = 0;
         if (m_ready() && $urandom_range(0, 9) == 0) begin
            cfg_we = 1; cfg_idx = 3'($urandom_range(0, 7));
            cfg_en = 1'($urandom_range(0, 1)); cfg_mod_en = 1'($urandom_range(0, 1));
            cfg_mod = 8'h10 + 8'($urandom_range(0, 7));
            cfg_key = 8'h10 + 8'($urandom_range(0, 7));
            cfg_act = 4'($urandom_range(0, 14));
         end
         ev_valid = ($urandom_range(0, 2) == 0);
         ev_ch    = 1'($urandom_range(0, 1));
         ev_key   = 8'h10 + 8'($urandom_range(0, 7));
         ev_down  = 1'($urandom_range(0, 1));
         ev_quit  = ($urandom_range(0, 19) == 0);
         rst_n    = (n != 1500);
         tick();
      end
      ev_valid = 0; ev_quit = 0; cfg_we = 0; rst_n = 1; act_ready = 1;
      repeat (20) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/key_chord_decoder.md
# key_chord_decoder

Parametrised hardware key-event decoder for the input path. It consumes a keyboard event stream from NUM_CH keyboards and tracks the held-key state per channel. Each key-down is matched against a programmable table of modifier+key chords. Each match produces an action-ID token into a small output FIFO that the window and app control logic drain. Quit events and chord actions such as fullscreen and log toggles leave as the same token type.

## Interface
- NUM_CH, 2, keyboard channels; CH_W = max(1, $clog2(NUM_CH))
- KEY_W, 8, key-code width; NUM_KEYS = 2**KEY_W held bits per channel
- NUM_CHORDS, 8, programmable chord entries; IDX_W = $clog2(NUM_CHORDS)
- ACT_W, 4, action-ID width; all-ones is reserved as ACT_QUIT
- FIFO_DEPTH, 4, action FIFO depth, power of two ≥ 2
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- ev_valid / ev_ready  in / out  1  event handshake; transfer when both high
- ev_ch  in  CH_W  source channel
- ev_key  in  KEY_W  key code
- ev_down  in  1  1 = key down, 0 = key up
- ev_quit  in  1  quit event; ev_key and ev_down ignored
- cfg_we  in  1  write chord entry cfg_idx
- cfg_idx  in  IDX_W  entry index
- cfg_en  in  1  entry valid
- cfg_mod_en  in  1  modifier required
- cfg_mod, cfg_key  in  KEY_W  modifier key code / trigger key code
- cfg_act  in  ACT_W  action ID to emit
- act_valid / act_ready  out / in  1  action handshake
- act_ch  out  CH_W  channel of action
- act_id  out  ACT_W  action ID
- held_any  out  NUM_CH  channel has at least one key held
- drop_cnt  out  16  saturating count of actions lost to a full FIFO

## Operation
- FSM states: IDLE, SCAN, PUSH. ev_ready is 1 only in IDLE.
- IDLE, accepted event:
  - Key up: clears held[ch][key] and stays in IDLE.
  - Key down: sets held[ch][key] at the same edge, latches ch/key, enters SCAN with idx = 0.
  - ev_quit: latches ch and ACT_QUIT, enters PUSH; held is unchanged.
  - ev_ch ≥ NUM_CH: event is accepted and discarded.
- SCAN, one entry per cycle:
  - Entry idx matches when en && key == latched key && (!mod_en || held[ch][mod]).
  - The lowest matching index wins; its act is latched and the FSM enters PUSH.
  - If idx = NUM_CHORDS-1 does not match, the FSM returns to IDLE.
- PUSH:
  - Writes {ch, act} to the FIFO if it is not full, or if it is full but act_ready && act_valid in the same cycle.
  - Otherwise drops the token and increments drop_cnt, saturating at 0xFFFF.
  - Always returns to IDLE.
- Chord table:
  - Registered; a cfg write takes effect the cycle after cfg_we.
  - An entry read by SCAN in the same cycle as its write returns the old contents.
- held_any[c] is the OR of the held bits of channel c.
- Reset values:
  - All held bits 0; all entries en = 0; FIFO empty.
  - act_valid 0, act_ch 0, act_id 0, held_any 0, drop_cnt 0.
  - ev_ready is 0 while rst_n is low and 1 in the first cycle after.
- Reset asserted mid-SCAN or mid-PUSH discards the latched event; no token is emitted.

## Timing
- Key down accepted at edge 0:
  - Entry i is examined in cycle 1+i.
  - A match at entry k gives PUSH in cycle 2+k and act_valid in cycle 3+k.
  - With no match, ev_ready returns in cycle 1+NUM_CHORDS.
- Quit accepted at edge 0: PUSH in cycle 1, act_valid in cycle 2, ev_ready in cycle 2.
- Key-up events may stream back-to-back at one per cycle.
- Action FIFO:
  - act_* are registered FIFO head outputs; the FIFO has no bypass.
  - Push and pop in the same cycle leave occupancy unchanged.
- A held bit set by an event is visible to the SCAN that begins on the next cycle.

## Configuration
- Macro: KCD_REPEAT_FILTER_EN.
- Defined:
  - A key-down for a key whose held bit is already 1 (autorepeat) updates nothing and goes straight back to IDLE.
  - Such an event triggers no scan and no action.
- Undefined: repeat key-downs are scanned like first presses and can emit repeated actions.

## Structure
- Package key_chord_pkg holds:
  - ACT_QUIT plus default action constants: ACT_FULLSCREEN = 1, ACT_LOG_TOGGLE = 2, ACT_STATUS = 3.
  - chord_entry_t struct {en, mod_en, mod, key, act}.
  - kcd_state_e enum.
- Sub-module kcd_action_fifo is the synchronous FIFO carrying {ch, act}, parametrised on FIFO_DEPTH and the payload width.

## Test plan
- Quit: with the table empty, drive ev_quit on ch 1 → act_ch = 1, act_id = 0xF two cycles later; drop_cnt = 0.
- Plain chord: program entry 0 as key 0x29 (escape), mod_en 0, act 0xF; press 0x29 on ch 0 → act_id 0xF at cycle 3; release → held_any[0] = 0.
- Modifier chord:
  - Program entry 2 as mod 0xE2, key 0x28, act 1.
  - Pressing 0x28 alone emits nothing.
  - Pressing 0xE2 then 0x28 emits act 1 at cycle 5 after the 0x28 accept.
  - Pressing 0xE2 on ch 1 and 0x28 on ch 0 emits nothing.
- Priority: entries 1 and 5 both match key 0x09 with acts 2 and 3 → exactly one token, act 2.
- FIFO full:
  - Hold act_ready = 0 and generate 6 quit events with FIFO_DEPTH = 4.
  - FIFO holds 4 tokens, drop_cnt = 2.
  - Then assert act_ready → 4 tokens drain in order.
- Repeat filter: press 0x44 twice without release → 2 tokens with the macro undefined, 1 token with KCD_REPEAT_FILTER_EN; reset mid-SCAN → no token, held_any = 0.
